// File: rtl/jtframe_dwnld_pack_pkg.sv
// Shared types for the ioctl-to-SDRAM byte packer: output FSM states and
// the active-low byte-mask encodings used on prog_mask.
package jtframe_dwnld_pack_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_e;

  localparam logic [1:0] MASK_LO   = 2'b10;  // low lane only (even byte)
  localparam logic [1:0] MASK_HI   = 2'b01;  // high lane only (odd byte)
  localparam logic [1:0] MASK_W    = 2'b00;  // full 16-bit word
  localparam logic [1:0] MASK_NONE = 2'b11;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is dropped and reported on
// drop_o, unless a pop frees a slot in the same cycle.
module jtframe_dwnld_fifo #(
  parameter int DW    = 31,
  parameter int FIFOW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          drop_o
);

  localparam int DEPTH = 2 ** FIFOW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [FIFOW:0] wr_q, rd_q;
  logic full, do_pop, do_push;

  assign empty_o = (wr_q == rd_q);
  assign full    = (wr_q[FIFOW] != rd_q[FIFOW]) &&
                   (wr_q[FIFOW-1:0] == rd_q[FIFOW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;
  assign dout_o  = mem_q[rd_q[FIFOW-1:0]];

  // NOTE: non-blocking (<=) in clocked blocks so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; empty pointers already
  // make stale contents unreachable, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[FIFOW-1:0]] <= din_i;
  end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl byte stream into masked 16-bit SDRAM writes (prog_* port)
// and keeps dwnld_busy high until the last word has been acknowledged.
module jtframe_dwnld_pack
  import jtframe_dwnld_pack_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int FIFOW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              ovf
);

  localparam int AW = SDRAMW + 1;  // byte address bits carried through
  localparam int DW = AW + 8;
  localparam logic [6:0] TMO = 7'd64;

  logic          unused_addr;
  logic [DW-1:0] fifo_dout;
  logic [AW-1:0] fifo_addr;
  logic [7:0]    fifo_data;
  logic          fifo_empty, fifo_drop, pop;

  logic          pend_valid_q;
  logic [AW-1:0] pend_addr_q;
  logic [7:0]    pend_data_q;
  logic [6:0]    tmo_cnt_q;
  logic          pend_load, pend_clr;

  logic              issue;
  logic [SDRAMW-1:0] w_addr;
  logic [15:0]       w_data;
  logic [1:0]        w_mask;

  state_e state_q;
  logic   dl_q, dl_rise;

  assign unused_addr = ^ioctl_addr[24:AW];
  assign fifo_addr   = fifo_dout[DW-1:8];
  assign fifo_data   = fifo_dout[7:0];
  assign dl_rise     = downloading && !dl_q;

  jtframe_dwnld_fifo #(.DW(DW), .FIFOW(FIFOW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ioctl_wr && downloading),
    .din_i   ({ioctl_addr[AW-1:0], ioctl_dout}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // Packer decision; only acts while the output FSM is idle.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    w_addr    = pend_addr_q[AW-1:1];
    w_data    = {pend_data_q, pend_data_q};
    w_mask    = MASK_LO;
    if (state_q == ST_IDLE) begin
      if (!fifo_empty) begin
        if (pend_valid_q) begin
          issue    = 1'b1;
          pend_clr = 1'b1;
          if (fifo_addr[0] && fifo_addr[AW-1:1] == pend_addr_q[AW-1:1]) begin
            pop    = 1'b1;
            w_data = {fifo_data, pend_data_q};
            w_mask = MASK_W;
          end
        end else if (fifo_addr[0]) begin
          pop    = 1'b1;
          issue  = 1'b1;
          w_addr = fifo_addr[AW-1:1];
          w_data = {fifo_data, fifo_data};
          w_mask = MASK_HI;
        end else begin
          pop       = 1'b1;
          pend_load = 1'b1;
        end
      end else if (pend_valid_q && (!downloading || tmo_cnt_q == TMO)) begin
        issue    = 1'b1;
        pend_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      if (pend_load) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= fifo_addr;
        pend_data_q  <= fifo_data;
      end else if (pend_clr) begin
        pend_valid_q <= 1'b0;
      end
      tmo_cnt_q <= (pend_valid_q && fifo_empty && !issue) ? tmo_cnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
    end else begin
      case (state_q)
        ST_IDLE: if (issue) begin
          prog_addr <= w_addr;
          prog_data <= w_data;
          prog_mask <= w_mask;
          prog_we   <= 1'b1;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: if (prog_rdy) begin
          prog_we <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q       <= 1'b0;
      ovf        <= 1'b0;
      dwnld_busy <= 1'b0;
    end else begin
      dl_q <= downloading;
      ovf  <= (ovf && !dl_rise) || fifo_drop;
      if (dl_rise)
        dwnld_busy <= 1'b1;
      else if (!downloading && fifo_empty && !pend_valid_q && state_q == ST_IDLE)
        dwnld_busy <= 1'b0;
    end
  end

endmodule
